// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART Lite AXI4-lite master controller.
package uart_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STAT_AR,
    ST_STAT_R,
    ST_DATA_AR,
    ST_DATA_R,
    ST_AW_W,
    ST_B
  } state_e;

  localparam logic [31:0] RX_FIFO_OFS = 32'h0000_0000;
  localparam logic [31:0] TX_FIFO_OFS = 32'h0000_0004;
  localparam logic [31:0] STAT_OFS    = 32'h0000_0008;

  localparam int STAT_RX_VALID = 0;
  localparam int STAT_TX_FULL  = 3;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  localparam logic GRANT_RX = 1'b0;
  localparam logic GRANT_TX = 1'b1;

endpackage

// File: rtl/uart_req_rr.sv
// Two-way round-robin picker between the TX producer and the RX consumer.
module uart_req_rr
  import uart_ctrl_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic tx_pend_i,
  input  logic rx_pend_i,
  input  logic take_i,
  output logic grant_valid_o,
  output logic grant_sel_o
);

  logic last_q;

  assign grant_valid_o = tx_pend_i | rx_pend_i;
  // With both pending, the side that did not win last time goes next.
  assign grant_sel_o = (tx_pend_i && rx_pend_i) ? ~last_q : tx_pend_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= GRANT_RX;
    end else if (take_i) begin
      last_q <= grant_sel_o;
    end
  end

endmodule

// File: rtl/uart_axi_ctrl.sv
// Single AXI4-lite bus owner for UART Lite: polls STAT, then moves one byte
// to the TX FIFO or from the RX FIFO per granted request.
module uart_axi_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned POLL_GAP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [7:0]  tx_data,
  input  logic        rx_req,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  output logic        busy,
  output logic        err,
  output logic        axi_awvalid,
  input  logic        axi_awready,
  output logic [31:0] axi_awaddr,
  output logic [2:0]  axi_awprot,
  output logic        axi_wvalid,
  input  logic        axi_wready,
  output logic [31:0] axi_wdata,
  output logic [3:0]  axi_wstrb,
  input  logic        axi_bvalid,
  output logic        axi_bready,
  input  logic [1:0]  axi_bresp,
  output logic        axi_arvalid,
  input  logic        axi_arready,
  output logic [31:0] axi_araddr,
  output logic [2:0]  axi_arprot,
  input  logic        axi_rvalid,
  output logic        axi_rready,
  input  logic [31:0] axi_rdata,
  input  logic [1:0]  axi_rresp
);

  state_e      state_q, state_d;
  logic        tx_pend_q, tx_pend_d;
  logic        rx_pend_q, rx_pend_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic [7:0]  gap_q, gap_d;
  logic        sel_q, sel_d;
  logic [31:0] araddr_q, araddr_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rx_valid_q, rx_valid_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        err_q, err_d;
  logic        take;
  logic        grant_valid, grant_sel;
  logic        unused_rdata;

  assign unused_rdata = ^axi_rdata[31:8];

  uart_req_rr u_rr (
    .clk_i        (clk),
    .rst_i        (rst),
    .tx_pend_i    (tx_pend_q),
    .rx_pend_i    (rx_pend_q),
    .take_i       (take),
    .grant_valid_o(grant_valid),
    .grant_sel_o  (grant_sel)
  );

  assign axi_awaddr  = BASE_ADDR + TX_FIFO_OFS;
  assign axi_awprot  = 3'b000;
  assign axi_arprot  = 3'b000;
  assign axi_wstrb   = 4'b0001;
  assign axi_awvalid = awvalid_q;
  assign axi_wvalid  = wvalid_q;
  assign axi_wdata   = wdata_q;
  assign axi_araddr  = araddr_q;
  assign axi_arvalid = (state_q == ST_STAT_AR) || (state_q == ST_DATA_AR);
  assign axi_rready  = (state_q == ST_STAT_R) || (state_q == ST_DATA_R);
  assign axi_bready  = (state_q == ST_B);
  assign tx_ready    = ~tx_pend_q;
  assign rx_valid    = rx_valid_q;
  assign rx_data     = rx_data_q;
  assign err         = err_q;
  assign busy        = (state_q != ST_IDLE) || tx_pend_q || rx_pend_q;

  always_comb begin
    state_d    = state_q;
    tx_pend_d  = tx_pend_q;
    tx_byte_d  = tx_byte_q;
    rx_pend_d  = rx_pend_q;
    gap_d      = gap_q;
    sel_d      = sel_q;
    araddr_d   = araddr_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    wdata_d    = wdata_q;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    err_d      = err_q;
    take       = 1'b0;

    if (tx_valid && !tx_pend_q) begin
      tx_pend_d = 1'b1;
      tx_byte_d = tx_data;
    end
    // The pulse cycle is excluded so a requester still holding rx_req while
    // it sees rx_valid does not immediately re-arm a second read.
    if (rx_req && !rx_pend_q && !rx_valid_q) begin
      rx_pend_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (gap_q != 8'd0) begin
          gap_d = gap_q - 8'd1;
        end else if (grant_valid) begin
          take     = 1'b1;
          sel_d    = grant_sel;
          araddr_d = BASE_ADDR + STAT_OFS;
          state_d  = ST_STAT_AR;
        end
      end
      ST_STAT_AR: if (axi_arready) state_d = ST_STAT_R;
      ST_STAT_R: begin
        if (axi_rvalid) begin
          if (axi_rresp != AXI_RESP_OKAY) err_d = 1'b1;
          if (axi_rresp == AXI_RESP_OKAY && sel_q == GRANT_RX && axi_rdata[STAT_RX_VALID]) begin
            araddr_d = BASE_ADDR + RX_FIFO_OFS;
            state_d  = ST_DATA_AR;
          end else if (axi_rresp == AXI_RESP_OKAY && sel_q == GRANT_TX && !axi_rdata[STAT_TX_FULL]) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            wdata_d   = {24'b0, tx_byte_q};
            state_d   = ST_AW_W;
          end else begin
            gap_d   = 8'(POLL_GAP);
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA_AR: if (axi_arready) state_d = ST_DATA_R;
      ST_DATA_R: begin
        if (axi_rvalid) begin
          if (axi_rresp != AXI_RESP_OKAY) err_d = 1'b1;
          rx_valid_d = 1'b1;
          rx_data_d  = axi_rdata[7:0];
          rx_pend_d  = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      ST_AW_W: begin
        if (axi_awready) awvalid_d = 1'b0;
        if (axi_wready)  wvalid_d  = 1'b0;
        if ((!awvalid_q || axi_awready) && (!wvalid_q || axi_wready)) state_d = ST_B;
      end
      ST_B: begin
        if (axi_bvalid) begin
          if (axi_bresp != AXI_RESP_OKAY) err_d = 1'b1;
          tx_pend_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    tx_byte_q <= tx_byte_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_pend_q  <= 1'b0;
      rx_pend_q  <= 1'b0;
      gap_q      <= 8'd0;
      sel_q      <= GRANT_RX;
      araddr_q   <= 32'd0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      wdata_q    <= 32'd0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= 8'd0;
      err_q      <= 1'b0;
    end else begin
      tx_pend_q  <= tx_pend_d;
      rx_pend_q  <= rx_pend_d;
      gap_q      <= gap_d;
      sel_q      <= sel_d;
      araddr_q   <= araddr_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      wdata_q    <= wdata_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_uart_axi_ctrl.sv
// Directed bench for uart_axi_ctrl with a small reactive AXI4-lite UART Lite slave.
module tb_uart_axi_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_valid = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic        rx_req = 1'b0;
  logic        tx_ready, rx_valid, busy, err;
  logic [7:0]  rx_data;
  logic        axi_awvalid, axi_wvalid, axi_bready, axi_arvalid, axi_rready;
  logic [31:0] axi_awaddr, axi_wdata, axi_araddr;
  logic [2:0]  axi_awprot, axi_arprot;
  logic [3:0]  axi_wstrb;
  logic        axi_awready = 1'b0, axi_wready = 1'b0, axi_bvalid = 1'b0;
  logic        axi_arready = 1'b0, axi_rvalid = 1'b0;
  logic [1:0]  axi_bresp = 2'b00, axi_rresp = 2'b00;
  logic [31:0] axi_rdata = 32'd0;

  always #5 clk = ~clk;

  uart_axi_ctrl #(.BASE_ADDR(32'h0000_0000), .POLL_GAP(4)) dut (
    .clk(clk), .rst(rst),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_req(rx_req), .rx_valid(rx_valid), .rx_data(rx_data),
    .busy(busy), .err(err),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr), .axi_arprot(axi_arprot),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp)
  );

  // Slave configuration, written only by the stimulus process.
  logic [31:0] stat_dflt = 32'd0;
  logic [31:0] stat_seq [4];
  int          stat_len = 0;
  int          stat_gen = 0;
  logic [31:0] rx_fifo_val = 32'h0000_005A;
  int          aw_delay = 0;
  logic [1:0]  bresp_cfg = 2'b00;
  logic        hold_rx_ar = 1'b0;

  // Handshakes seen at the last rising edge, plus monitor statistics.
  logic        ar_hs = 0, r_hs = 0, aw_hs = 0, w_hs = 0, b_hs = 0;
  logic [31:0] ar_addr_h = 0;
  int          cyc = 0, stat_reads = 0, rx_reads = 0, aw_cnt = 0, rx_pulses = 0;
  int          last_stat_cyc = 0, poll_gap = 0, aw_at_stat = 0;
  logic [31:0] last_awaddr = 0, last_wdata = 0;
  logic [3:0]  last_wstrb = 0;
  logic [7:0]  last_rx = 0;
  logic        op_log [$];

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    ar_hs     <= axi_arvalid && axi_arready;
    ar_addr_h <= axi_araddr;
    r_hs      <= axi_rvalid && axi_rready;
    aw_hs     <= axi_awvalid && axi_awready;
    w_hs      <= axi_wvalid && axi_wready;
    b_hs      <= axi_bvalid && axi_bready;
    if (axi_arvalid && axi_arready) begin
      if (axi_araddr == 32'h8) begin
        stat_reads    <= stat_reads + 1;
        last_stat_cyc <= cyc;
        poll_gap      <= cyc - last_stat_cyc;
      end else if (axi_araddr == 32'h0) begin
        rx_reads <= rx_reads + 1;
        op_log.push_back(1'b0);
      end
    end
    if (axi_awvalid && axi_awready) begin
      aw_cnt      <= aw_cnt + 1;
      last_awaddr <= axi_awaddr;
      aw_at_stat  <= stat_reads;
      op_log.push_back(1'b1);
    end
    if (axi_wvalid && axi_wready) begin
      last_wdata <= axi_wdata;
      last_wstrb <= axi_wstrb;
    end
    if (rx_valid) begin
      rx_pulses <= rx_pulses + 1;
      last_rx   <= rx_data;
    end
  end

  int   sp = 0, seen_gen = 0, awd_cnt = 0;
  logic aw_done = 0, w_done = 0;

  always @(negedge clk) begin
    if (seen_gen != stat_gen) begin
      sp       = 0;
      seen_gen = stat_gen;
    end
    if (r_hs) axi_rvalid = 1'b0;
    if (ar_hs) begin
      axi_arready = 1'b0;
      axi_rvalid  = 1'b1;
      axi_rresp   = 2'b00;
      if (ar_addr_h == 32'h8) begin
        if (sp < stat_len) begin
          axi_rdata = stat_seq[sp];
          sp        = sp + 1;
        end else begin
          axi_rdata = stat_dflt;
        end
      end else begin
        axi_rdata = rx_fifo_val;
      end
    end else if (axi_arvalid && !axi_arready && !axi_rvalid && !(hold_rx_ar && axi_araddr == 32'h0)) begin
      axi_arready = 1'b1;
    end
    if (b_hs) axi_bvalid = 1'b0;
    if (aw_hs) begin
      axi_awready = 1'b0;
      aw_done     = 1'b1;
      awd_cnt     = 0;
    end else if (axi_awvalid && !axi_awready) begin
      if (awd_cnt == aw_delay) axi_awready = 1'b1;
      else awd_cnt = awd_cnt + 1;
    end
    if (w_hs) begin
      axi_wready = 1'b0;
      w_done     = 1'b1;
    end else if (axi_wvalid && !axi_wready) begin
      axi_wready = 1'b1;
    end
    if (aw_done && w_done && !axi_bvalid) begin
      axi_bvalid = 1'b1;
      axi_bresp  = bresp_cfg;
      aw_done    = 1'b0;
      w_done     = 1'b0;
    end
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_tx(input logic [7:0] b);
    int n;
    n = 0;
    while (!tx_ready && n < 1000) begin
      tick;
      n++;
    end
    chk("tx_ready_wait", tx_ready, 1);
    tx_valid = 1'b1;
    tx_data  = b;
    tick;
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    repeat (2) tick;
    while (busy && n < 2000) begin
      tick;
      n++;
    end
    chk(tag, busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int s0, a0, r0, p0, o0, n;

    // Reset values
    repeat (3) tick;
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_arvalid", axi_arvalid, 0);
    chk("rst_awvalid", axi_awvalid, 0);
    chk("rst_wvalid", axi_wvalid, 0);
    chk("rst_rready", axi_rready, 0);
    chk("rst_bready", axi_bready, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_araddr", axi_araddr, 0);
    chk("rst_wstrb", axi_wstrb, 4'b0001);
    rst = 1'b0;
    tick;

    // 1: single TX write with ready UART
    s0 = stat_reads; a0 = aw_cnt; r0 = rx_reads;
    stat_dflt = 32'h0;
    send_tx(8'h41);
    chk("t1_tx_ready_low", tx_ready, 0);
    wait_idle("t1_idle");
    chk("t1_stat_reads", stat_reads - s0, 1);
    chk("t1_rx_reads", rx_reads - r0, 0);
    chk("t1_aw_cnt", aw_cnt - a0, 1);
    chk("t1_awaddr", last_awaddr, 32'h4);
    chk("t1_wdata", last_wdata, 32'h41);
    chk("t1_wstrb", last_wstrb, 4'b0001);
    chk("t1_prot", {axi_awprot, axi_arprot}, 6'b0);
    chk("t1_tx_ready", tx_ready, 1);
    chk("t1_err", err, 0);

    // 2: RX after two not-ready polls
    s0 = stat_reads; r0 = rx_reads; p0 = rx_pulses;
    stat_seq[0] = 32'h0; stat_seq[1] = 32'h0; stat_seq[2] = 32'h1;
    stat_len = 3; stat_gen++;
    stat_dflt = 32'h1; rx_fifo_val = 32'h5A;
    rx_req = 1'b1;
    n = 0;
    while (!rx_valid && n < 2000) begin
      tick;
      n++;
    end
    chk("t2_rx_valid", rx_valid, 1);
    chk("t2_rx_data", rx_data, 8'h5A);
    rx_req = 1'b0;
    wait_idle("t2_idle");
    chk("t2_stat_reads", stat_reads - s0, 3);
    chk("t2_poll_gap", poll_gap, 7);
    chk("t2_rx_reads", rx_reads - r0, 1);
    chk("t2_pulses", rx_pulses - p0, 1);

    // 3: TX FIFO full for three polls
    s0 = stat_reads; a0 = aw_cnt;
    stat_seq[0] = 32'h8; stat_seq[1] = 32'h8; stat_seq[2] = 32'h8; stat_seq[3] = 32'h0;
    stat_len = 4; stat_gen++;
    send_tx(8'h33);
    wait_idle("t3_idle");
    chk("t3_stat_reads", stat_reads - s0, 4);
    chk("t3_aw_after_poll", aw_at_stat - s0, 4);
    chk("t3_aw_cnt", aw_cnt - a0, 1);
    chk("t3_wdata", last_wdata, 32'h33);
    chk("t3_poll_gap", poll_gap, 7);
    stat_len = 0; stat_gen++;

    // 4: contention alternates RX/TX
    stat_dflt = 32'h1;
    o0 = op_log.size(); p0 = rx_pulses;
    rx_req = 1'b1;
    tick;
    tx_valid = 1'b1; tx_data = 8'h10;
    n = 0;
    while ((op_log.size() - o0) < 8 && n < 3000) begin
      tick;
      n++;
    end
    tx_valid = 1'b0; rx_req = 1'b0;
    wait_idle("t4_idle");
    chk("t4_ops", (op_log.size() - o0) >= 8, 1);
    if ((op_log.size() - o0) >= 8) begin
      for (int i = 0; i < 8; i++) chk($sformatf("t4_order%0d", i), op_log[o0 + i], i % 2);
    end
    chk("t4_tx_byte", last_wdata, 32'h10);
    chk("t4_rx_byte", last_rx, 8'h5A);
    chk("t4_err", err, 0);

    // 5: AW channel skew
    stat_dflt = 32'h0; aw_delay = 3;
    send_tx(8'h5C);
    n = 0;
    while (!(axi_awvalid && axi_wvalid) && n < 200) begin
      tick;
      n++;
    end
    chk("t5_enter", axi_awvalid && axi_wvalid, 1);
    tick;
    chk("t5_wvalid_drop", axi_wvalid, 0);
    chk("t5_aw_hold1", axi_awvalid, 1);
    chk("t5_awaddr", axi_awaddr, 32'h4);
    chk("t5_no_b1", axi_bready, 0);
    tick;
    chk("t5_aw_hold2", axi_awvalid, 1);
    tick;
    chk("t5_aw_hold3", axi_awvalid, 1);
    chk("t5_no_b3", axi_bready, 0);
    tick;
    chk("t5_aw_done", axi_awvalid, 0);
    chk("t5_b_state", axi_bready, 1);
    wait_idle("t5_idle");
    chk("t5_wdata", last_wdata, 32'h5C);
    aw_delay = 0;

    // 6a: error response on B
    bresp_cfg = 2'b10;
    send_tx(8'h77);
    wait_idle("t6a_idle");
    chk("t6a_err", err, 1);
    chk("t6a_tx_ready", tx_ready, 1);
    bresp_cfg = 2'b00;
    repeat (5) tick;
    chk("t6a_err_sticky", err, 1);

    // 6b: reset while in DATA_AR
    stat_dflt = 32'h1; hold_rx_ar = 1'b1;
    p0 = rx_pulses;
    rx_req = 1'b1;
    n = 0;
    while (!(axi_arvalid && axi_araddr == 32'h0) && n < 200) begin
      tick;
      n++;
    end
    chk("t6b_in_data_ar", axi_arvalid, 1);
    rst = 1'b1; rx_req = 1'b0;
    tick;
    chk("t6b_arvalid", axi_arvalid, 0);
    chk("t6b_araddr", axi_araddr, 0);
    chk("t6b_rready", axi_rready, 0);
    chk("t6b_awvalid", axi_awvalid, 0);
    chk("t6b_tx_ready", tx_ready, 1);
    chk("t6b_rx_data", rx_data, 0);
    chk("t6b_err", err, 0);
    chk("t6b_busy", busy, 0);
    rst = 1'b0; hold_rx_ar = 1'b0;
    repeat (20) tick;
    chk("t6b_no_pulse", rx_pulses - p0, 0);
    chk("t6b_quiet", axi_arvalid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
